// File: rtl/ahb_sram_slave_pkg.sv
// rtl/ahb_sram_slave_pkg.sv - shared response codes, FSM states and widths for the SRAM slave
package ahb_sram_slave_pkg;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;
  localparam int SRAM_WAIT_W = 4;

  typedef enum logic [1:0] {IDLE, BUSY, RESP, ERR} sram_state_t;
endpackage

// File: rtl/ahb_sram_slave_if.sv
// rtl/ahb_sram_slave_if.sv - data-phase request/response bundle between AHB wrapper and SRAM slave
interface ahb_sram_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  write_en;
  logic                  read_en;
  logic [DATA_WIDTH-1:0] read_data;
  logic                  ready;
  logic [1:0]            resp;

  modport master (
    output addr, write_data, write_en, read_en,
    input  read_data, ready, resp
  );

  modport slave (
    input  addr, write_data, write_en, read_en,
    output read_data, ready, resp
  );
endinterface

// File: rtl/ahb_sram_slave_mem_array.sv
// rtl/ahb_sram_slave_mem_array.sv - single-port word RAM, synchronous write and synchronous read
module ahb_sram_slave_mem_array #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 32,
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic             re,
  input  logic [IDX_W-1:0] idx,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
    if (re) rdata <= mem[idx];
  end
endmodule

// File: rtl/ahb_sram_slave.sv
// rtl/ahb_sram_slave.sv - AHB data-phase SRAM slave with programmable wait states and
// two-cycle ERROR response for misaligned or out-of-range addresses
module ahb_sram_slave
  import ahb_sram_slave_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    MEM_DEPTH   = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    WAIT_STATES = 1
) (
  input  logic            clk,
  input  logic            reset,
  ahb_sram_slave_if.slave bus
);
  localparam int IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int SPAN_W = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] SPAN = SPAN_W'(MEM_DEPTH) << 2;

  if (WAIT_STATES < 1 || WAIT_STATES > 15) begin : g_bad_wait_states
    $error("ahb_sram_slave: WAIT_STATES must be in 1..15");
  end
  if (DATA_WIDTH != 32) begin : g_bad_data_width
    $error("ahb_sram_slave: only DATA_WIDTH=32 is supported");
  end

  sram_state_t            state;
  logic [SRAM_WAIT_W-1:0] cnt;
  logic [IDX_W-1:0]       idx_q;
  logic [DATA_WIDTH-1:0]  wdata_q;
  logic                   is_wr_q;
  logic                   rd_valid;

  logic                  req, bad, accept, fire, fire_wr;
  logic [ADDR_WIDTH:0]   diff;
  logic [IDX_W-1:0]      idx_now, mem_idx;
  logic [DATA_WIDTH-1:0] mem_wdata, mem_rdata;

  // A borrow out of the subtraction makes diff exceed SPAN, so one compare covers both range edges.
  assign diff    = {1'b0, bus.addr} - {1'b0, BASE_ADDR};
  assign idx_now = IDX_W'(diff >> 2);
  assign req     = bus.write_en | bus.read_en;
  assign bad     = (bus.addr[1:0] != 2'b00) || (diff >= SPAN);
  assign accept  = (state == IDLE) && req && !bad;

  // The memory is accessed on the edge that enters RESP; with one wait state that is the request cycle itself.
  assign fire      = (accept && WAIT_STATES == 1) || (state == BUSY && cnt == SRAM_WAIT_W'(1));
  assign fire_wr   = (state == IDLE) ? bus.write_en : is_wr_q;
  assign mem_idx   = (state == IDLE) ? idx_now : idx_q;
  assign mem_wdata = (state == IDLE) ? bus.write_data : wdata_q;

  ahb_sram_slave_mem_array #(.DEPTH(MEM_DEPTH), .WIDTH(DATA_WIDTH)) u_mem (
    .clk   (clk),
    .we    (fire && fire_wr),
    .re    (fire && !fire_wr),
    .idx   (mem_idx),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      idx_q    <= '0;
      wdata_q  <= '0;
      is_wr_q  <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      if (fire && !fire_wr) rd_valid <= 1'b1;
      case (state)
        IDLE: begin
          if (req) begin
            if (bad) begin
              state <= ERR;
            end else begin
              idx_q   <= idx_now;
              wdata_q <= bus.write_data;
              is_wr_q <= bus.write_en;
              if (WAIT_STATES == 1) begin
                state <= RESP;
              end else begin
                state <= BUSY;
                cnt   <= SRAM_WAIT_W'(WAIT_STATES - 1);
              end
            end
          end
        end
        BUSY: begin
          cnt <= cnt - SRAM_WAIT_W'(1);
          if (cnt == SRAM_WAIT_W'(1)) state <= RESP;
        end
        RESP:    state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // read_data reads as zero until the first read completes after reset.
  assign bus.read_data = rd_valid ? mem_rdata : '0;

  always_comb begin
    bus.ready = 1'b1;
    bus.resp  = RESP_OKAY;
    case (state)
      IDLE: begin
        if (req) begin
          bus.ready = 1'b0;
          bus.resp  = bad ? RESP_ERROR : RESP_OKAY;
        end
      end
      BUSY:    bus.ready = 1'b0;
      ERR:     bus.resp  = RESP_ERROR;
      default: ;
    endcase
  end
endmodule

// File: doc/ahb_sram_slave.md
Name: ahb_sram_slave

Overview:
- Memory-backed slave core sitting directly downstream of the AHB slave wrapper.
- Consumes the wrapper's registered data-phase request (addr, write_data, write_en/read_en pulses).
- Returns read_data, ready (drives Hreadyout) and resp (drives Hresp).
- Provides a word-addressed SRAM with a programmable wait-state count, plus an AHB two-cycle ERROR response for out-of-range or misaligned accesses.

Parameters:
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width; only 32 is supported.
- MEM_DEPTH, 1024, number of 32-bit words.
- BASE_ADDR, 32'h0000_0000, byte address of word 0.
- WAIT_STATES, 1, ready-low cycles per OKAY transfer; legal range 1..15; elaborate-time error outside that range.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- addr  input  ADDR_WIDTH  byte address; valid while write_en or read_en is high.
- write_data  input  DATA_WIDTH  write word; valid with write_en.
- write_en  input  1  one-cycle write request pulse.
- read_en  input  1  one-cycle read request pulse.
- read_data  output  DATA_WIDTH  read word; valid when ready=1 in the RESP state.
- ready  output  1  transfer-complete indication (Hreadyout).
- resp  output  2  00 OKAY, 01 ERROR.

Behaviour:
- req = write_en | read_en. If both are high, the write wins and the read is dropped.
- Reset values (asynchronous assert): state IDLE, ready=1, resp=OKAY, read_data=0, wait counter 0. Any in-flight write is discarded. Memory contents are not reset.
- bad = addr[1:0]!=0, or addr<BASE_ADDR, or (addr-BASE_ADDR)>=MEM_DEPTH*4. Word index = (addr-BASE_ADDR)>>2, clog2(MEM_DEPTH) bits.
- ready and resp are combinational from state, req and bad:
  - IDLE with no req: ready=1, resp=OKAY.
  - IDLE with req: ready=0 in the same cycle, because the request cycle is the AHB data phase.
- FSM states: IDLE, BUSY, RESP, ERR.
- IDLE & req & bad:
  - ready=0, resp=ERROR this cycle; next state is ERR.
  - No memory access; no wait states applied.
- IDLE & req & !bad:
  - Latch index, write_data and direction.
  - If WAIT_STATES==1, next state is RESP; otherwise next state is BUSY with counter=WAIT_STATES-1.
- BUSY: ready=0, resp=OKAY; counter decrements each cycle. On the cycle counter==1, next state is RESP.
- Entering RESP:
  - Write: mem[index] <= latched data.
  - Read: read_data <= mem[index].
- RESP: ready=1, resp=OKAY. Next state is IDLE.
- ERR: ready=1, resp=ERROR. Next state is IDLE. read_data and memory are unchanged.
- Latency: an OKAY transfer gives exactly WAIT_STATES ready-low cycles, then one ready-high cycle. An ERROR transfer gives exactly one ready-low cycle, then one ready-high cycle.
- Back-to-back: a req in the cycle after RESP or ERR (state IDLE) is accepted normally with no bubble.
- req in BUSY, RESP or ERR is a protocol violation: it is ignored and does not disturb the current transfer.
- read_data holds its last read value at all times except on read completion.
- Reset mid-transfer (BUSY/RESP/ERR): returns to IDLE immediately; a pending write is not committed.
- Read-after-write to the same word must return the new data.

Decomposition:
- Added to param_pkg:
  - RESP_OKAY=2'b00, RESP_ERROR=2'b01.
  - Typedef enum logic [1:0] sram_state_t {IDLE, BUSY, RESP, ERR}.
  - SRAM_WAIT_W=4.
- Sub-module slave_mem_array: single-port, synchronous write, synchronous read, parameters DEPTH and WIDTH, ports clk, we, re, idx, wdata, rdata.
- The FSM, counter and range check remain in ahb_sram_slave.

Test Plan:
- Reset: reset=1 mid-stream -> ready=1, resp=00, read_data=0 on the same cycle; a write pulsed at addr 0x10 immediately before reset is not visible on a later read.
- WAIT_STATES=3: write 0xDEADBEEF to 0x40, then read 0x40 -> each transfer shows ready low for 3 cycles then high for 1; read_data=0xDEADBEEF in the read's RESP cycle; resp=00 throughout.
- Error: read at 0x1000 (MEM_DEPTH=1024) and at 0x42 -> cycle 1 ready=0/resp=01, cycle 2 ready=1/resp=01, then IDLE; read_data unchanged; a write to 0x1000 leaves word 0 unchanged.
- Back-to-back (WAIT_STATES=1): write 0x11111111 to 0x0, req asserted the cycle after RESP; then read 0x0 -> second transfer accepted with no idle cycle; read_data=0x11111111.
- Simultaneous write_en=read_en=1 at 0x8, data 0xA5A5A5A5 -> treated as a write; a subsequent read of 0x8 returns 0xA5A5A5A5.
- Spurious read_en pulse during BUSY -> ignored; the current transfer completes with its original timing and data.
